// File: rtl/prog_seq_gen_pkg.sv
// Shared types and constants for the programmable sequence generator.
package prog_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Standard power-up sequence inherited from the fixed 8-bit generator.
  localparam logic [7:0] DEFAULT_SEQ [0:7] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  // Default word for table entry i; indices past 7 wrap onto the 8-word sequence.
  function automatic logic [7:0] default_word(input int unsigned i);
    return DEFAULT_SEQ[i[2:0]];
  endfunction

endpackage

// File: rtl/prog_seq_table.sv
// DEPTH x DATA_W pattern register file: one write port, one combinational read
// port, asynchronous reset to the standard sequence.
module prog_seq_table
  import prog_seq_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next table contents: apply the write strobe, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Table storage with reset to the default pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(default_word(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Write-through read: a write landing this cycle is visible to a reader
  // capturing on the same edge (start and write together play the new word).
  assign rd_data = mem_d[rd_addr];

endmodule

// File: rtl/prog_seq_gen.sv
// Programmable pattern sequencer: plays a writable table as a valid/ready
// stream in loop or one-shot mode.
module prog_seq_gen
  import prog_seq_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              done,
  output logic              busy,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1'b1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              wr_err_q, wr_err_d;

  logic              accept_s;
  logic              at_last_s;
  logic              tbl_wr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;

  assign accept_s  = valid_q && ready && enable;
  assign at_last_s = (idx_q == last_q);
  assign tbl_wr_s  = wr_en && (state_q == ST_IDLE);

  prog_seq_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (tbl_wr_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Read address: the word that will be presented after the next transition.
  always_comb begin
    if (state_q == ST_RUN && !at_last_s) begin
      rd_addr_s = idx_q + IDX_ONE;
    end else begin
      rd_addr_s = IDX_ZERO;
    end
  end

  // FSM state register plus index, config and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_ZERO;
      last_q   <= IDX_ZERO;
      mode_q   <= MODE_LOOP;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Next-state logic; enable gates every transition except the DONE pulse exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable && stop) begin
          state_d = ST_IDLE;
        end else if (accept_s && at_last_s && (mode_q == MODE_ONESHOT)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/output next values: index stepping, word fetch, valid handshake.
  always_comb begin
    idx_d    = idx_q;
    last_d   = last_q;
    mode_d   = mode_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
    wr_err_d = wr_en && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start && enable) begin
          idx_d   = IDX_ZERO;
          last_d  = cfg_last;
          mode_d  = cfg_mode;
          data_d  = rd_data_s;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (enable && stop) begin
          valid_d = 1'b0;
        end else if (accept_s) begin
          if (!at_last_s) begin
            idx_d  = idx_q + IDX_ONE;
            data_d = rd_data_s;
          end else if (mode_q == MODE_LOOP) begin
            idx_d  = IDX_ZERO;
            data_d = rd_data_s;
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DONE: valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_prog_seq_gen.sv
// Directed bench for prog_seq_gen with a transaction-level reference model
// compared every cycle, plus literal expectations that pin the model.
module tb_prog_seq_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cfg_mode = 1'b0;
  logic [2:0] cfg_last = 3'd7;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       done;
  logic       busy;
  logic       wr_err;

  int n_chk  = 0;
  int n_pass = 0;

  prog_seq_gen #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_last(cfg_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .data(data), .valid(valid), .ready(ready), .done(done),
    .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_tbl [8];
  logic       m_play, m_done, m_err, m_mode;
  int         m_pos, m_last;
  logic [7:0] m_data;
  logic [7:0] std_seq [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_tbl[i] = std_seq[i];
      m_play = 1'b0; m_done = 1'b0; m_err = 1'b0; m_mode = 1'b0;
      m_pos = 0; m_last = 0; m_data = 8'h00;
    end else begin
      logic was_busy;
      was_busy = m_play || m_done;
      m_err = wr_en && was_busy;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_play) begin
        if (wr_en) m_tbl[wr_addr] = wr_data;
        if (start && enable) begin
          m_play = 1'b1; m_pos = 0; m_mode = cfg_mode; m_last = int'(cfg_last);
          m_data = m_tbl[0];
        end
      end else if (enable) begin
        if (stop) begin
          m_play = 1'b0;
        end else if (ready) begin
          if (m_pos < m_last) begin
            m_pos = m_pos + 1;
            m_data = m_tbl[m_pos];
          end else if (!m_mode) begin
            m_pos = 0;
            m_data = m_tbl[0];
          end else begin
            m_play = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", int'(valid), int'(m_play));
    chk("m_busy", int'(busy), int'(m_play || m_done));
    chk("m_done", int'(done), int'(m_done));
    chk("m_wr_err", int'(wr_err), int'(m_err));
    chk("m_data", int'(data), int'(m_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    step(); step();
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step();

    // 1: loop over the full table
    cfg_mode = 1'b0; cfg_last = 3'd7; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("loop_data", int'(data), int'(std_seq[k % 8]));
      chk("loop_valid", int'(valid), 1);
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_valid", int'(valid), 0);

    // 2: backpressure holds BC
    start = 1'b1; step(); start = 1'b0;
    chk("bp_first", int'(data), 8'hAF);
    step();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold", int'(data), 8'hBC);
      chk("bp_valid", int'(valid), 1);
    end
    ready = 1'b1; step();
    chk("bp_next", int'(data), 8'hE2);
    stop = 1'b1; step(); stop = 1'b0;

    // 3: one-shot of three words
    cfg_mode = 1'b1; cfg_last = 3'd2; start = 1'b1; step(); start = 1'b0;
    chk("os_w0", int'(data), 8'hAF); step();
    chk("os_w1", int'(data), 8'hBC); step();
    chk("os_w2", int'(data), 8'hE2); step();
    chk("os_done", int'(done), 1);
    chk("os_valid", int'(valid), 0);
    step();
    chk("os_done_clr", int'(done), 0);
    chk("os_busy", int'(busy), 0);

    // 4: write together with start, then a dropped write in RUN
    cfg_mode = 1'b0; cfg_last = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55; start = 1'b1;
    step(); start = 1'b0; wr_en = 1'b0;
    chk("wr_first", int'(data), 8'h55);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99;
    step(); wr_en = 1'b0;
    chk("wr_err", int'(wr_err), 1);
    chk("wr_unchanged", int'(data), 8'hBC);
    step();
    chk("wr_err_clr", int'(wr_err), 0);
    stop = 1'b1; step(); stop = 1'b0;

    // cfg_last=0: single-word loop repeats table[0]
    cfg_last = 3'd0; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("one_word", int'(data), 8'h55);
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;

    // 5: enable freeze at 78, stop with accept, async reset mid-run
    cfg_last = 3'd7; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("en_78", int'(data), 8'h78);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_hold", int'(data), 8'h78);
    end
    enable = 1'b1; stop = 1'b1; step(); stop = 1'b0;
    chk("stop_acc_valid", int'(valid), 0);
    chk("stop_acc_done", int'(done), 0);
    start = 1'b1; step(); start = 1'b0; step();
    #2 reset_n = 1'b0; #1;
    chk("arst_valid", int'(valid), 0);
    step(); reset_n = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    chk("arst_replay", int'(data), 8'hAF);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
